// File: rtl/rk4_sequencer_if.sv
// Control bus between the RK4 sequencer and its host/datapath.
// RK4_SEQ_CYCLE_CNT_EN adds the 32-bit cycle_cnt status signal.
interface rk4_sequencer_if #(
  parameter int N_ITER_W = 16
);
  // start is a request: it is taken only on an edge where the sequencer is idle
  // (busy low), so busy acts as the inverted ready; start while busy is dropped.
  logic                start;
  logic                abort;
  logic [N_ITER_W-1:0] n_iter;
  logic                sel;
  logic                step;
  logic                ld;
  logic [N_ITER_W-1:0] iter_cnt;
  logic                busy;
  logic                done;
`ifdef RK4_SEQ_CYCLE_CNT_EN
  logic [31:0]         cycle_cnt;

  modport master (
    output start, abort, n_iter,
    input  sel, step, ld, iter_cnt, busy, done, cycle_cnt
  );
  modport slave (
    input  start, abort, n_iter,
    output sel, step, ld, iter_cnt, busy, done, cycle_cnt
  );
`else
  modport master (
    output start, abort, n_iter,
    input  sel, step, ld, iter_cnt, busy, done
  );
  modport slave (
    input  start, abort, n_iter,
    output sel, step, ld, iter_cnt, busy, done
  );
`endif
endinterface

// File: rtl/rk4_sequencer.sv
// Phase/iteration sequencer for a recirculating RK4 datapath (IDLE/SEED/RUN/FIN).
// Define RK4_SEQ_CYCLE_CNT_EN to add a saturating busy-cycle counter (bus.cycle_cnt).
module rk4_sequencer #(
  parameter int N_ITER_W = 16,
  parameter int PIPE_LAT = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  rk4_sequencer_if.slave bus,
  output logic [1:0]     state_dbg
);
  localparam int PH_W = $clog2(PIPE_LAT);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SEED = 2'd1, RUN = 2'd2, FIN = 2'd3} state_t;

  state_t              state, state_n;
  logic [PH_W-1:0]     ph, ph_n;
  logic [N_ITER_W-1:0] n_lat, n_lat_n;
  logic [N_ITER_W-1:0] cnt, cnt_n;
  logic                step_n, ld_n;
  logic                step_q, ld_q, sel_q, busy_q, done_q;

  // Outputs are registered from next-state values, so abort sampled on the edge
  // that produces a step still lets the step through but withholds its ld.
  always_comb begin
    state_n = state;
    ph_n    = ph;
    n_lat_n = n_lat;
    cnt_n   = cnt;
    step_n  = 1'b0;
    ld_n    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          n_lat_n = bus.n_iter;
          cnt_n   = '0;
          ph_n    = '0;
          state_n = (bus.n_iter == '0) ? FIN : SEED;
        end
      end
      SEED, RUN: begin
        ph_n    = (ph == PH_LAST) ? '0 : ph + 1'b1;
        state_n = ld_q ? FIN : RUN;
        if (!ld_q && (ph_n == PH_LAST)) begin
          step_n = 1'b1;
          cnt_n  = cnt + 1'b1;
          ld_n   = ((cnt + 1'b1) == n_lat);
        end
        if (bus.abort) begin
          state_n = IDLE;
          ld_n    = 1'b0;
        end
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ph     <= '0;
      n_lat  <= '0;
      cnt    <= '0;
      step_q <= 1'b0;
      ld_q   <= 1'b0;
      sel_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      ph     <= ph_n;
      n_lat  <= n_lat_n;
      cnt    <= cnt_n;
      step_q <= step_n;
      ld_q   <= ld_n;
      sel_q  <= (state_n == RUN) || (state_n == FIN);
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == FIN);
    end
  end

  assign bus.sel      = sel_q;
  assign bus.step     = step_q;
  assign bus.ld       = ld_q;
  assign bus.iter_cnt = cnt;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign state_dbg    = state;

`ifdef RK4_SEQ_CYCLE_CNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
    end else if ((state == IDLE) && bus.start) begin
      cyc_cnt <= '0;
    end else if (busy_q && (cyc_cnt != 32'hFFFF_FFFF)) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end

  assign bus.cycle_cnt = cyc_cnt;
`endif
endmodule
